// File: rtl/elbeth_memory_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elbeth_memory_responder_pkg
// Description : Shared definitions for the ELBETH memory responder: FSM state
//               encodings, the read opcode and the legal byte-lane write
//               masks, plus a helper that classifies a write mask.
// Revision    : 1.0 - initial release
// ============================================================================
package elbeth_memory_responder_pkg;

   // Responder FSM state encodings
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // A request with an all-zero lane mask is a read
   localparam logic [3:0] c_op_read = 4'b0000;

   // Legal write masks: single bytes, aligned halfwords, full word
   localparam logic [3:0] c_mask_b0 = 4'b0001;
   localparam logic [3:0] c_mask_b1 = 4'b0010;
   localparam logic [3:0] c_mask_b2 = 4'b0100;
   localparam logic [3:0] c_mask_b3 = 4'b1000;
   localparam logic [3:0] c_mask_h0 = 4'b0011;
   localparam logic [3:0] c_mask_h1 = 4'b1100;
   localparam logic [3:0] c_mask_w  = 4'b1111;

   function automatic logic is_legal_mask(input logic [3:0] mask);
      return (mask == c_mask_b0) || (mask == c_mask_b1) ||
             (mask == c_mask_b2) || (mask == c_mask_b3) ||
             (mask == c_mask_h0) || (mask == c_mask_h1) ||
             (mask == c_mask_w);
   endfunction

endpackage : elbeth_memory_responder_pkg
`default_nettype wire

// File: rtl/elbeth_memory_responder_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : elbeth_mem_array
// Description : Synchronous DEPTH_WORDS x 32 word RAM with a byte-enable
//               write port and a registered read port sharing one address.
// Ports       : clk    - clock
//               addr   - word index (always < DEPTH_WORDS)
//               we, be - write strobe and per-byte lane enables
//               wdata  - write data
//               re     - read strobe; rdata updates on the same edge
//               rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module elbeth_mem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_WIDTH   = 10
) (
   input  logic                 clk,
   input  logic [IDX_WIDTH-1:0] addr,
   input  logic                 we,
   input  logic [3:0]           be,
   input  logic [31:0]          wdata,
   input  logic                 re,
   output logic [31:0]          rdata
);

   // Storage is deliberately not reset: contents survive a responder reset.
   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we && be[b]) begin
            mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule : elbeth_mem_array
`default_nettype wire

// File: rtl/elbeth_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : elbeth_memory_responder
// Description : Memory-side target for an ELBETH core memory port. Accepts
//               one en/addr/rw/data request at a time, inserts WAIT_CYCLES
//               wait states, performs the access on the edge entering RESP
//               and returns a one-cycle ready strobe with registered data.
// Ports       : clk          - clock
//               rst          - asynchronous active-low reset
//               mem_en       - request valid, held until mem_ready
//               mem_addr     - byte address, [ADDR_WIDTH-1:2] = word index
//               mem_rw       - 0000 read, otherwise byte-lane write mask
//               mem_in_data  - write data
//               mem_out_data - read data (valid with ready & !error)
//               mem_ready    - one-cycle response strobe
//               mem_error    - error flag, qualified by mem_ready
// Config      : define ELBETH_MEM_ERROR_EN to reject out-of-range word
//               indices and illegal write masks; otherwise the index wraps
//               modulo DEPTH_WORDS and every nonzero mask writes its lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module elbeth_memory_responder
   import elbeth_memory_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_en,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [3:0]            mem_rw,
   input  logic [31:0]           mem_in_data,
   output logic [31:0]           mem_out_data,
   output logic                  mem_ready,
   output logic                  mem_error
);

   localparam int c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] c_cnt_init =
      (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   generate
      if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
         $error("WAIT_CYCLES must be in 0..15");
      end
      if (ADDR_WIDTH < 3) begin : g_bad_addr_width
         $error("ADDR_WIDTH must be at least 3");
      end
   endgenerate

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic        error_q, error_d;
   logic        rd_valid_q, rd_valid_d;

   logic        w_access;
   logic        w_is_read;
   logic        w_illegal;
   logic [31:0] w_word_idx;
   logic [c_idx_w-1:0] w_arr_idx;
   logic [31:0] w_rdata;
   logic        w_unused_ok;

   // Byte offset is irrelevant: sub-word reads return the whole word.
   assign w_unused_ok = &{1'b1, mem_addr[1:0]};

   assign w_is_read  = (mem_rw == c_op_read);
   assign w_word_idx = 32'(mem_addr[ADDR_WIDTH-1:2]);

   // Always fold the index into range so the array is never addressed out
   // of bounds; with checking enabled an out-of-range request is rejected
   // before it can touch storage.
   assign w_arr_idx = c_idx_w'(w_word_idx % 32'(DEPTH_WORDS));

`ifdef ELBETH_MEM_ERROR_EN
   assign w_illegal = (w_word_idx >= 32'(DEPTH_WORDS)) ||
                      (!w_is_read && !is_legal_mask(mem_rw));
`else
   assign w_illegal = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ready_d    = 1'b0;
      error_d    = 1'b0;
      rd_valid_d = 1'b0;
      w_access   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (mem_en) begin
               if (WAIT_CYCLES == 0) begin
                  w_access = 1'b1;
                  state_d  = ST_RESP;
               end else begin
                  cnt_d   = c_cnt_init;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!mem_en) begin
               // Core withdrew the request: abandon it silently.
               cnt_d   = 4'd0;
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               w_access = 1'b1;
               state_d  = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
         end
      endcase

      // The response registers are loaded on the access edge so they are
      // valid throughout the RESP cycle.
      if (w_access) begin
         ready_d    = 1'b1;
         error_d    = w_illegal;
         rd_valid_d = w_is_read && !w_illegal;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         ready_q    <= 1'b0;
         error_q    <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   elbeth_mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_WIDTH   (c_idx_w)
   ) u_mem_array (
      .clk   (clk),
      .addr  (w_arr_idx),
      .we    (w_access && !w_is_read && !w_illegal),
      .be    (mem_rw),
      .wdata (mem_in_data),
      .re    (w_access && w_is_read && !w_illegal),
      .rdata (w_rdata)
   );

   // The RAM read register is not reset, so the data output is gated by a
   // reset-cleared flag; writes and errors therefore return zero.
   assign mem_out_data = rd_valid_q ? w_rdata : 32'd0;
   assign mem_ready    = ready_q;
   assign mem_error    = error_q;

endmodule : elbeth_memory_responder
`default_nettype wire
